// File: rtl/nextpc_btb_unit.sv
// rtl/nextpc_btb_unit.sv - next-fetch-PC selection with a direct-mapped branch target buffer
module nextpc_btb_unit #(
   parameter int PC_W      = 16,
   parameter int BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [PC_W-1:0] if_pc,
   input  logic            ex_valid,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [1:0]      ex_type,
   input  logic            ex_taken,
   input  logic [PC_W-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [PC_W-1:0] ex_pred_target,
   output logic [PC_W-1:0] nextpc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   output logic            mispredict
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = PC_W - IDX_W - 2;

   localparam logic [1:0] T_OTHER  = 2'd0;
   localparam logic [1:0] T_JALR   = 2'd1;
   localparam logic [1:0] T_BRANCH = 2'd2;
   localparam logic [1:0] T_JAL    = 2'd3;

   logic [BTB_DEPTH-1:0] valid_q;
   logic [1:0]           ctr_q    [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
   logic [PC_W-1:0]      target_q [BTB_DEPTH];
   logic [1:0]           type_q   [BTB_DEPTH];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [PC_W-1:0]  if_pc_inc;
   logic             lk_hit;
   logic             lk_uncond;

   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic [PC_W-1:0]  ex_pc_inc;
   logic [PC_W-1:0]  redirect_pc;
   logic             ex_hit;
   logic             upd_en;
   logic             upd_hit;
   logic             upd_alloc;
   logic [1:0]       ctr_d;

   // Lookup side: purely combinational read of the pre-update array contents.
   assign if_idx    = if_pc[IDX_W+1:2];
   assign if_tag    = if_pc[PC_W-1:IDX_W+2];
   assign if_pc_inc = if_pc + PC_W'(4);

   assign lk_hit     = ~rst & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
   assign lk_uncond  = (type_q[if_idx] == T_JAL) | (type_q[if_idx] == T_JALR);
   assign pred_taken  = lk_hit & (lk_uncond | ctr_q[if_idx][1]);
   assign pred_target = lk_hit ? target_q[if_idx] : if_pc_inc;

   // Resolve side.
   assign ex_idx      = ex_pc[IDX_W+1:2];
   assign ex_tag      = ex_pc[PC_W-1:IDX_W+2];
   assign ex_pc_inc   = ex_pc + PC_W'(4);
   assign redirect_pc = ex_taken ? ex_target : ex_pc_inc;

   assign mispredict = ex_valid & ~rst &
                       ((ex_pred_taken != ex_taken) |
                        (ex_taken & (ex_pred_target != ex_target)));

   always_comb begin
      nextpc = if_pc_inc;
      if (mispredict) begin
         nextpc = redirect_pc;
      end else if (stall) begin
         nextpc = if_pc;
      end else if (pred_taken) begin
         nextpc = pred_target;
      end
   end

   assign ex_hit    = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
   assign upd_en    = ex_valid & (ex_type != T_OTHER);
   assign upd_hit   = upd_en & ex_hit;
   assign upd_alloc = upd_en & ~ex_hit & ex_taken;

   always_comb begin
      ctr_d = ctr_q[ex_idx];
      if (upd_alloc) begin
         ctr_d = 2'b10;
      end else if (upd_hit && (ex_type == T_BRANCH)) begin
         if (ex_taken && (ctr_q[ex_idx] != 2'b11)) begin
            ctr_d = ctr_q[ex_idx] + 2'd1;
         end else if (!ex_taken && (ctr_q[ex_idx] != 2'b00)) begin
            ctr_d = ctr_q[ex_idx] - 2'd1;
         end
      end
   end

   // Only valid and ctr need a defined reset value; tag/target/type are
   // qualified by valid, so they simply hold while reset is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else begin
         if (upd_alloc) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
            type_q[ex_idx]   <= ex_type;
         end
         if (upd_hit) begin
            type_q[ex_idx] <= ex_type;
            if (ex_taken) begin
               target_q[ex_idx] <= ex_target;
            end
         end
         if (upd_hit || upd_alloc) begin
            ctr_q[ex_idx] <= ctr_d;
         end
      end
   end

endmodule

// File: tb/tb_nextpc_btb_unit.sv
// tb/tb_nextpc_btb_unit.sv - randomized bench for nextpc_btb_unit against a behavioural BTB model
module tb_nextpc_btb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [15:0] if_pc;
   logic        ex_valid;
   logic [15:0] ex_pc;
   logic [1:0]  ex_type;
   logic        ex_taken;
   logic [15:0] ex_target;
   logic        ex_pred_taken;
   logic [15:0] ex_pred_target;
   logic [15:0] nextpc;
   logic        pred_taken;
   logic [15:0] pred_target;
   logic        mispredict;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a table keyed by entry number, holding the full tag as an integer.
   int m_valid  [16];
   int m_tag    [16];
   int m_target [16];
   int m_type   [16];
   int m_ctr    [16];

   nextpc_btb_unit #(.PC_W(16), .BTB_DEPTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .if_pc          (if_pc),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_type        (ex_type),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .nextpc         (nextpc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .mispredict     (mispredict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
   endfunction

   function automatic int slot(input int pc);
      return (pc / 4) % 16;
   endfunction

   function automatic int tagof(input int pc);
      return pc / 64;
   endfunction

   function automatic void model_update();
      int s;
      int hit;
      if (rst || !ex_valid || ex_type == 0) return;
      s   = slot(int'(ex_pc));
      hit = m_valid[s] && (m_tag[s] == tagof(int'(ex_pc)));
      if (hit) begin
         if (ex_type == 2) begin
            if (ex_taken) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
            else          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
         end
         if (ex_taken) m_target[s] = int'(ex_target);
         m_type[s] = int'(ex_type);
      end else if (ex_taken) begin
         m_valid[s]  = 1;
         m_tag[s]    = tagof(int'(ex_pc));
         m_target[s] = int'(ex_target);
         m_type[s]   = int'(ex_type);
         m_ctr[s]    = 2;
      end
   endfunction

   // Compare all outputs for the current inputs, then let one edge pass.
   task automatic cycle(input string tag);
      int s, hit, e_pt, e_ptg, e_mp, e_np;
      @(negedge clk);
      s     = slot(int'(if_pc));
      hit   = !rst && m_valid[s] && (m_tag[s] == tagof(int'(if_pc)));
      e_pt  = hit && (m_type[s] == 1 || m_type[s] == 3 || m_ctr[s] >= 2);
      e_ptg = hit ? m_target[s] : (int'(if_pc) + 4) % 65536;
      e_mp  = ex_valid && !rst &&
              ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
      if (e_mp)       e_np = ex_taken ? int'(ex_target) : (int'(ex_pc) + 4) % 65536;
      else if (stall) e_np = int'(if_pc);
      else if (e_pt)  e_np = e_ptg;
      else            e_np = (int'(if_pc) + 4) % 65536;
      check({tag, ".pt"},  32'(pred_taken),  32'(e_pt));
      check({tag, ".ptg"}, 32'(pred_target), 32'(e_ptg));
      check({tag, ".mp"},  32'(mispredict),  32'(e_mp));
      check({tag, ".np"},  32'(nextpc),      32'(e_np));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [15:0] pc, input logic [1:0] typ,
                         input logic tk, input logic [15:0] tgt,
                         input logic ptk, input logic [15:0] ptgt);
      ex_valid = v; ex_pc = pc; ex_type = typ; ex_taken = tk;
      ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; if_pc = 16'h0040;
      model_reset();
      // Mismatching resolve while in reset must not redirect nor train.
      set_ex(1'b1, 16'h0040, 2'd2, 1'b1, 16'h0020, 1'b0, 16'h0044);
      cycle("rst_a");
      check("rst_np_const", 32'(nextpc), 32'h0044);
      stall = 1'b1;
      cycle("rst_stall");
      #2 rst = 1'b0; stall = 1'b0; idle_ex();

      if_pc = 16'h0040; cycle("post_rst40");
      check("post_rst40_np", 32'(nextpc), 32'h0044);
      if_pc = 16'hFFFC; cycle("wrap");
      check("wrap_np", 32'(nextpc), 32'h0000);

      // First taken branch: redirect, lookup in same cycle sees old contents.
      if_pc = 16'h0040;
      set_ex(1'b1, 16'h0040, 2'd2, 1'b1, 16'h0020, 1'b0, 16'h0044);
      cycle("br_alloc");
      idle_ex(); cycle("br_hit");
      check("br_hit_np", 32'(nextpc), 32'h0020);

      set_ex(1'b1, 16'h0040, 2'd2, 1'b0, 16'h0020, 1'b1, 16'h0020);
      cycle("br_nt");
      idle_ex(); cycle("br_weak");
      check("br_weak_pt", 32'(pred_taken), 32'd0);

      for (int i = 0; i < 4; i++) begin
         set_ex(1'b1, 16'h0040, 2'd2, 1'b1, 16'h0020, 1'b1, 16'h0020);
         cycle("br_sat");
      end
      set_ex(1'b1, 16'h0040, 2'd2, 1'b0, 16'h0020, 1'b1, 16'h0020);
      cycle("br_sat_nt");
      idle_ex(); cycle("br_sat_chk");
      check("br_sat_pt", 32'(pred_taken), 32'd1);

      set_ex(1'b1, 16'h0440, 2'd3, 1'b1, 16'h0100, 1'b0, 16'h0444);
      cycle("jal_alloc");
      idle_ex(); if_pc = 16'h0440; cycle("alias_440");
      check("alias_440_np", 32'(nextpc), 32'h0100);
      if_pc = 16'h0040; cycle("alias_040");
      check("alias_040_np", 32'(nextpc), 32'h0044);

      stall = 1'b1;
      set_ex(1'b1, 16'h0080, 2'd2, 1'b1, 16'h0300, 1'b0, 16'h0084);
      cycle("stall_mp");
      check("stall_mp_np", 32'(nextpc), 32'h0300);
      stall = 1'b0; idle_ex();

      for (int n = 0; n < 600; n++) begin
         logic [1:0] typ;
         logic       tk;
         logic [15:0] tgt;
         stall = ($urandom_range(0, 3) == 0);
         if_pc = ($urandom_range(0, 15) == 0) ? 16'hFFFC
               : 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
         typ = 2'($urandom_range(0, 3));
         tk  = (typ == 2'd0) ? 1'b0 : (typ == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b1;
         tgt = 16'($urandom_range(0, 16383) << 2);
         set_ex(1'($urandom_range(0, 1)),
                16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)),
                typ, tk, tgt, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? tgt : 16'($urandom_range(0, 65535)));
         cycle("rnd");
         if (n == 300) begin
            // Train 0x0040 then reset mid-cycle with a pending update; next lookup must miss.
            set_ex(1'b1, 16'h0040, 2'd3, 1'b1, 16'h0200, 1'b1, 16'h0200);
            cycle("pre_rst");
            set_ex(1'b1, 16'h00C0, 2'd3, 1'b1, 16'h0600, 1'b0, 16'h0000);
            #2 rst = 1'b1;
            model_reset();
            if_pc = 16'h0040;
            cycle("mid_rst");
            #2 rst = 1'b0; idle_ex();
            cycle("after_rst");
            check("after_rst_pt", 32'(pred_taken), 32'd0);
            if_pc = 16'h00C0; cycle("after_rst_c0");
            check("after_rst_c0_pt", 32'(pred_taken), 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
